// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, port ids and access-size helper for the DMEM arbiter
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        P_CORE = 1'b0,
        P_DBG  = 1'b1
    } port_id_t;

    // Bytes touched by an access; 0 marks an unsupported width code.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            F3_W:        access_size = 3'd4;
            default:     access_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_chk.sv
// rtl/dmem_access_chk.sv - combinational width/alignment/range fault check for one DMEM access
module dmem_access_chk
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic              we,
    output logic              fault
);

    // One extra bit so an access running past the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    logic [2:0]      size;
    logic [ADDR_W:0] end_addr;
    logic            bad_code;
    logic            narrow_store;
    logic            mis_half;
    logic            mis_word;
    logic            out_of_range;

    // Classify the access; any single condition is enough to fault it.
    always_comb begin
        size         = access_size(funct3);
        end_addr     = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, size};
        bad_code     = (size == 3'd0);
        narrow_store = we && ((funct3 == F3_BU) || (funct3 == F3_HU));
        mis_half     = (size == 3'd2) && addr[0];
        mis_word     = (size == 3'd4) && (addr[1:0] != 2'b00);
        // last byte = end_addr - 1, so last >= MEM_BYTES  <=>  end_addr > MEM_BYTES
        out_of_range = end_addr > MEM_LIMIT;
        fault        = bad_code || narrow_store || mis_half || mis_word || out_of_range;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port DMEM arbiter with port-1 anti-starvation; optional DMEM_ARB_LOCK_EN adds lock1
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic [2:0]        funct3_0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    input  logic [2:0]        funct3_1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rd_data
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       force1;
    logic       grant;
    logic       sel_we;
    logic       fault;
    port_id_t   sel;
`ifdef DMEM_ARB_LOCK_EN
    logic       lock_q;
`endif

    // Fixed priority to the core unless the loader has waited MAX_WAIT cycles (or holds the lock).
    always_comb begin
        force1 = req1 && (wait_cnt == WAIT_LIM);
        gnt1   = req1 && (!req0 || force1);
`ifdef DMEM_ARB_LOCK_EN
        gnt0   = req0 && !gnt1 && !lock_q;
`else
        gnt0   = req0 && !gnt1;
`endif
        grant  = gnt0 || gnt1;
        sel    = gnt1 ? P_DBG : P_CORE;
    end

    // Steer the granted port onto the memory pins; idle cycles show port 0 with enables low.
    always_comb begin
        if (sel == P_DBG) begin
            mem_addr    = addr1;
            mem_wr_data = wdata1;
            mem_funct3  = funct3_1;
            sel_we      = we1;
        end else begin
            mem_addr    = addr0;
            mem_wr_data = wdata0;
            mem_funct3  = funct3_0;
            sel_we      = we0;
        end
        mem_rd_en = grant && !sel_we && !fault;
        mem_wr_en = grant && sel_we && !fault;
    end

    dmem_access_chk #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_chk (
        .addr   (mem_addr),
        .funct3 (mem_funct3),
        .we     (sel_we),
        .fault  (fault)
    );

    // One-cycle response per accepted access; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            rdata0  <= (gnt0 && mem_rd_en) ? mem_rd_data : 32'h0;
            rdata1  <= (gnt1 && mem_rd_en) ? mem_rd_data : 32'h0;
            err0    <= gnt0 && fault;
            err1    <= gnt1 && fault;
        end
    end

    // Count consecutive denied cycles of port 1, saturating at the force threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!req1 || gnt1) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock follows lock1 on every port-1 acceptance and drops whenever port 1 goes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (!req1) begin
            lock_q <= 1'b0;
        end else if (gnt1) begin
            lock_q <= lock1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-array DMEM model
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 4096;
    localparam int MAX_WAIT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [2:0]  funct3_0 = 3'd2, funct3_1 = 3'd2;
`ifdef DMEM_ARB_LOCK_EN
    logic        lock1 = 1'b0;
`endif
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic [2:0]  mem_funct3;

    dmem_arbiter #(
        .ADDR_W    (32),
        .MEM_BYTES (MEM_BYTES),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .funct3_0    (funct3_0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .funct3_1    (funct3_1),
`ifdef DMEM_ARB_LOCK_EN
        .lock1       (lock1),
`endif
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .err0        (err0),
        .err1        (err1),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_funct3  (mem_funct3),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] dmem    [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t q0[$];
    resp_t q1[$];

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [7:0] b3, input logic [7:0] b2,
                                         input logic [7:0] b1, input logic [7:0] b0);
        case (f3)
            3'd0:    ext = {{24{b0[7]}}, b0};
            3'd4:    ext = {24'h0, b0};
            3'd1:    ext = {{16{b1[7]}}, b1, b0};
            3'd5:    ext = {16'h0, b1, b0};
            3'd2:    ext = {b3, b2, b1, b0};
            default: ext = 32'h0;
        endcase
    endfunction

    function automatic logic model_fault(input logic [31:0] a, input logic [2:0] f3, input logic we);
        int sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (sz == 0) return 1'b1;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        if (sz == 2 && a[0]) return 1'b1;
        if (sz == 4 && a[1:0] != 2'b00) return 1'b1;
        if ((64'(a) + 64'(sz)) > 64'(MEM_BYTES)) return 1'b1;
        return 1'b0;
    endfunction

    // DMEM model: combinational extended read, store on the rising edge.
    logic [11:0] ma;
    logic [7:0]  m0, m1, m2, m3;
    assign ma = mem_addr[11:0];
    assign m0 = dmem[ma];
    assign m1 = dmem[ma + 12'd1];
    assign m2 = dmem[ma + 12'd2];
    assign m3 = dmem[ma + 12'd3];
    assign mem_rd_data = ext(mem_funct3, m3, m2, m1, m0);

    always @(posedge clk) begin
        if (mem_wr_en) begin
            dmem[ma] = mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'd0) dmem[ma + 12'd1] = mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'd2) begin
                dmem[ma + 12'd2] = mem_wr_data[23:16];
                dmem[ma + 12'd3] = mem_wr_data[31:24];
            end
        end
    end

    // Scoreboard monitor: pop/compare responses, then push the access accepted this cycle.
    resp_t       mon_e;
    logic        mon_f;
    logic [11:0] mon_i;
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            checks++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                errors++;
                $display("FAIL rvalid_in_reset: got %b expected 00", {rvalid0, rvalid1});
            end
        end else begin
            checks++;
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid0_unexpected: got rvalid0=1 expected 0");
                end else begin
                    mon_e = q0.pop_front();
                    if (rdata0 !== mon_e.rdata || err0 !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp0: got rdata=%h err=%b expected rdata=%h err=%b",
                                 rdata0, err0, mon_e.rdata, mon_e.err);
                    end
                end
            end else if (rdata0 !== 32'h0 || err0 !== 1'b0) begin
                errors++;
                $display("FAIL idle0: got rdata=%h err=%b expected 0", rdata0, err0);
            end
            checks++;
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid1_unexpected: got rvalid1=1 expected 0");
                end else begin
                    mon_e = q1.pop_front();
                    if (rdata1 !== mon_e.rdata || err1 !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp1: got rdata=%h err=%b expected rdata=%h err=%b",
                                 rdata1, err1, mon_e.rdata, mon_e.err);
                    end
                end
            end else if (rdata1 !== 32'h0 || err1 !== 1'b0) begin
                errors++;
                $display("FAIL idle1: got rdata=%h err=%b expected 0", rdata1, err1);
            end
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL dual_grant: got gnt0=1 gnt1=1 expected at most one");
            end
            if ((req0 && gnt0) || (req1 && gnt1)) begin
                logic        p_we;
                logic [31:0] p_a, p_wd;
                logic [2:0]  p_f3;
                p_we = gnt1 ? we1 : we0;
                p_a  = gnt1 ? addr1 : addr0;
                p_wd = gnt1 ? wdata1 : wdata0;
                p_f3 = gnt1 ? funct3_1 : funct3_0;
                mon_f = model_fault(p_a, p_f3, p_we);
                mon_i = p_a[11:0];
                mon_e.err   = mon_f;
                mon_e.rdata = (!p_we && !mon_f) ?
                              ext(p_f3, ref_mem[mon_i + 12'd3], ref_mem[mon_i + 12'd2],
                                  ref_mem[mon_i + 12'd1], ref_mem[mon_i]) : 32'h0;
                if (gnt1) q1.push_back(mon_e); else q0.push_back(mon_e);
                checks++;
                if (mem_rd_en !== (!p_we && !mon_f) || mem_wr_en !== (p_we && !mon_f) || mem_addr !== p_a) begin
                    errors++;
                    $display("FAIL mem_pins: got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                             mem_rd_en, mem_wr_en, mem_addr, !p_we && !mon_f, p_we && !mon_f, p_a);
                end
                if (p_we && !mon_f) begin
                    ref_mem[mon_i] = p_wd[7:0];
                    if (p_f3[1:0] != 2'd0) ref_mem[mon_i + 12'd1] = p_wd[15:8];
                    if (p_f3[1:0] == 2'd2) begin
                        ref_mem[mon_i + 12'd2] = p_wd[23:16];
                        ref_mem[mon_i + 12'd3] = p_wd[31:24];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < MEM_BYTES; i++) begin
            dmem[i]    = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        {dmem[16'h13], dmem[16'h12], dmem[16'h11], dmem[16'h10]}             = 32'hDEADBEEF;
        {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]} = 32'hDEADBEEF;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_wr_en, mem_rd_en} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_wr_en, mem_rd_en});
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0, rdata1);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; funct3_0 = 3'd2;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL load_gnt: got gnt0=%b rd_en=%b expected 1 1", gnt0, mem_rd_en);
        end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || err0 !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: got v=%b d=%h e=%b expected 1 deadbeef 0", rvalid0, rdata0, err0);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic exp1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; funct3_0 = 3'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14; funct3_1 = 3'd2;
        for (int c = 0; c < 2 * (MAX_WAIT + 1); c++) begin
            exp1 = ((c % (MAX_WAIT + 1)) == MAX_WAIT);
            @(negedge clk);
            checks++;
            if (gnt0 !== !exp1 || gnt1 !== exp1) begin
                errors++;
                $display("FAIL fair_c%0d: got gnt0=%b gnt1=%b expected %b %b", c, gnt0, gnt1, !exp1, exp1);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic        flt;
    } fcase_t;

    task automatic test_faults();
        fcase_t tbl[11];
        tbl[0]  = '{1'b1, 32'h102,  3'd2, 32'hCAFEF00D, 1'b1};
        tbl[1]  = '{1'b0, 32'hFFF,  3'd1, 32'h0,        1'b1};
        tbl[2]  = '{1'b0, 32'hFFC,  3'd2, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h1000, 3'd2, 32'h0,        1'b1};
        tbl[4]  = '{1'b0, 32'hFFF,  3'd0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'hFFE,  3'd5, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 32'h40,   3'd4, 32'h77,       1'b1};
        tbl[7]  = '{1'b0, 32'h40,   3'd3, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h40,   3'd6, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h41,   3'd1, 32'h5555,     1'b1};
        tbl[10] = '{1'b1, 32'h42,   3'd1, 32'h1234BEEF, 1'b0};
        for (int k = 0; k < 11; k++) begin
            req1 = 1'b1; we1 = tbl[k].we; addr1 = tbl[k].addr; funct3_1 = tbl[k].f3; wdata1 = tbl[k].wd;
            @(negedge clk);
            checks++;
            if (gnt1 !== 1'b1 || (mem_rd_en | mem_wr_en) !== !tbl[k].flt) begin
                errors++;
                $display("FAIL fault_k%0d: got gnt1=%b en=%b expected 1 %b", k, gnt1, mem_rd_en | mem_wr_en, !tbl[k].flt);
            end
            tick();
        end
        req1 = 1'b0;
        tick();
        checks++;
        if ({dmem[16'h105], dmem[16'h104], dmem[16'h103], dmem[16'h102]} !== {8'h5F, 8'h5E, 8'h59, 8'h58}) begin
            errors++;
            $display("FAIL sw_fault_mem: got %h expected 5f5e5958",
                     {dmem[16'h105], dmem[16'h104], dmem[16'h103], dmem[16'h102]});
        end
        checks++;
        if ({dmem[16'h43], dmem[16'h42], dmem[16'h41], dmem[16'h40]} !== 32'hBEEF1B1A) begin
            errors++;
            $display("FAIL sh_mem: got %h expected beef1b1a",
                     {dmem[16'h43], dmem[16'h42], dmem[16'h41], dmem[16'h40]});
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; funct3_0 = 3'd0; wdata0 = 32'h000000A5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL sb_gnt: got gnt0=%b wr_en=%b expected 1 1", gnt0, mem_wr_en);
        end
        tick();
        we0 = 1'b0; funct3_0 = 3'd4;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || rvalid0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overlap: got gnt0=%b rvalid0=%b expected 1 1", gnt0, rvalid0);
        end
        tick();
        funct3_0 = 3'd0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h000000A5) begin
            errors++;
            $display("FAIL lbu_resp: got v=%b d=%h expected 1 000000a5", rvalid0, rdata0);
        end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hFFFFFFA5) begin
            errors++;
            $display("FAIL lb_resp: got v=%b d=%h expected 1 ffffffa5", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; funct3_0 = 3'd2;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt: got %b expected 1", gnt0);
        end
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        checks++;
        if ({rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_wr_en, mem_rd_en} !== 8'h00 || rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b rdata0=%h expected 0",
                     {rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_wr_en, mem_rd_en}, rdata0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_rvalid_c%0d: got %b expected 0", c, rvalid0);
            end
            tick();
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        int found;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80; funct3_1 = 3'd2; lock1 = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_lw_gnt: got %b expected 1", gnt1);
        end
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; funct3_0 = 3'd2;
        we1 = 1'b1; wdata1 = 32'h11223344; lock1 = 1'b0;
        found = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== 1'b0) begin
                errors++;
                $display("FAIL lock_gnt0_c%0d: got %b expected 0", i, gnt0);
            end
            if (gnt1 === 1'b1) begin
                found = i;
                break;
            end
            tick();
        end
        checks++;
        if (found != MAX_WAIT) begin
            errors++;
            $display("FAIL lock_sw_cycle: got %0d expected %0d", found, MAX_WAIT);
        end
        tick();
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: got gnt0=%b expected 1", gnt0);
        end
        tick();
        req0 = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_fairness();
        test_faults();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        tick();
        tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
